// File: rtl/wb_sequencer.sv
// wb_sequencer -- write-back sequencer in front of the integer/float register file.
//
// Accepts write-back requests over a valid/ready handshake, buffers them in a
// small FIFO and issues at most one register-file write per cycle from
// registered outputs. Per-register pending vectors mark registers whose writes
// are still buffered so hazard logic can stall dependent reads.
//
// Optional feature (macro WB_BYPASS_EN): a request accepted while the FIFO is
// empty loads the output register directly at its acceptance edge.
//
// Ports:
//   clk            clock, all state on posedge
//   reset          asynchronous active-high reset
//   req_valid      request present
//   req_ready      request accepted at this edge when req_valid && req_ready
//   req_kind       00 integer, 01 float single, 10 float double, 11 reserved
//   req_reg        destination register
//   req_data       data for req_reg
//   req_data2      data for req_reg+1 (double only)
//   regWSig        integer-bank write strobe
//   regwrite_float float-bank write strobe
//   double         paired float write (wData2 -> wReg+1)
//   wReg           write address
//   wData          write data
//   wData2         second write data (0 for non-double writes)
//   int_pending    per-register: integer write buffered, not yet issued
//   float_pending  per-register: float write buffered, not yet issued
//   err            one-cycle pulse after a dropped request
//   idle           FIFO empty and no strobe this cycle
module wb_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_kind,
    input  logic [REG_AW-1:0]      req_reg,
    input  logic [DATA_W-1:0]      req_data,
    input  logic [DATA_W-1:0]      req_data2,
    output logic                   regWSig,
    output logic                   regwrite_float,
    output logic                   double,
    output logic [REG_AW-1:0]      wReg,
    output logic [DATA_W-1:0]      wData,
    output logic [DATA_W-1:0]      wData2,
    output logic [2**REG_AW-1:0]   int_pending,
    output logic [2**REG_AW-1:0]   float_pending,
    output logic                   err,
    output logic                   idle
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] KIND_INT = 2'b00;
    localparam logic [1:0] KIND_SGL = 2'b01;
    localparam logic [1:0] KIND_DBL = 2'b10;
    localparam logic [1:0] KIND_RSV = 2'b11;

    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [REG_AW-1:0] REG_ONE  = REG_AW'(1);

    // FIFO storage
    logic [1:0]        kind_mem  [DEPTH];
    logic [REG_AW-1:0] reg_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];
    logic [DATA_W-1:0] data2_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic accept;
    logic drop;
    logic store;
    logic push;
    logic pop;
    logic [DEPTH-1:0] entry_valid;

    assign req_ready = (count_reg < CNT_FULL);
    assign accept    = req_valid && req_ready;
    // A double to the last register would wrap its second half to register 0.
    assign drop      = (req_kind == KIND_RSV) ||
                       ((req_kind == KIND_DBL) && (req_reg == '1));
    assign store     = accept && !drop;
    assign pop       = (count_reg != '0);

`ifdef WB_BYPASS_EN
    logic bypass;
    // Pop only happens with count>0, so bypass and pop are mutually exclusive.
    assign bypass = store && (count_reg == '0);
    assign push   = store && !bypass;
`else
    assign push   = store;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            kind_mem[wr_ptr_reg]  <= req_kind;
            reg_mem[wr_ptr_reg]   <= req_reg;
            data_mem[wr_ptr_reg]  <= req_data;
            data2_mem[wr_ptr_reg] <= req_data2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (push && !pop)
                count_reg <= count_reg + CNT_ONE;
            else if (pop && !push)
                count_reg <= count_reg - CNT_ONE;
        end
    end

    // Registered write port towards the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWSig        <= 1'b0;
            regwrite_float <= 1'b0;
            double         <= 1'b0;
            wReg           <= '0;
            wData          <= '0;
            wData2         <= '0;
            err            <= 1'b0;
        end else begin
            err <= accept && drop;
            if (pop) begin
                regWSig        <= (kind_mem[rd_ptr_reg] == KIND_INT);
                regwrite_float <= (kind_mem[rd_ptr_reg] != KIND_INT);
                double         <= (kind_mem[rd_ptr_reg] == KIND_DBL);
                wReg           <= reg_mem[rd_ptr_reg];
                wData          <= data_mem[rd_ptr_reg];
                wData2         <= (kind_mem[rd_ptr_reg] == KIND_DBL) ?
                                  data2_mem[rd_ptr_reg] : '0;
`ifdef WB_BYPASS_EN
            end else if (bypass) begin
                regWSig        <= (req_kind == KIND_INT);
                regwrite_float <= (req_kind != KIND_INT);
                double         <= (req_kind == KIND_DBL);
                wReg           <= req_reg;
                wData          <= req_data;
                wData2         <= (req_kind == KIND_DBL) ? req_data2 : '0;
`endif
            end else begin
                // Address and data hold; only the strobes drop.
                regWSig        <= 1'b0;
                regwrite_float <= 1'b0;
                double         <= 1'b0;
            end
        end
    end

    assign idle = (count_reg == '0) && !regWSig && !regwrite_float;

    // Slot gi is live when its distance from the read pointer is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic [PTR_W-1:0] offset;
            assign offset          = PTR_W'(gi) - rd_ptr_reg;
            assign entry_valid[gi] = ({1'b0, offset} < count_reg);
        end
    endgenerate

    always_comb begin
        int_pending   = '0;
        float_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                case (kind_mem[i])
                    KIND_INT: int_pending[reg_mem[i]] = 1'b1;
                    KIND_SGL: float_pending[reg_mem[i]] = 1'b1;
                    KIND_DBL: begin
                        float_pending[reg_mem[i]]           = 1'b1;
                        float_pending[reg_mem[i] + REG_ONE] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
module tb_wb_sequencer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;
    localparam int VW     = 139;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_kind;
    logic [REG_AW-1:0] req_reg;
    logic [DATA_W-1:0] req_data;
    logic [DATA_W-1:0] req_data2;
    logic              regWSig;
    logic              regwrite_float;
    logic              double;
    logic [REG_AW-1:0] wReg;
    logic [DATA_W-1:0] wData;
    logic [DATA_W-1:0] wData2;
    logic [NREG-1:0]   int_pending;
    logic [NREG-1:0]   float_pending;
    logic              err;
    logic              idle;

    wb_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_reg(req_reg), .req_data(req_data), .req_data2(req_data2),
        .regWSig(regWSig), .regwrite_float(regwrite_float), .double(double),
        .wReg(wReg), .wData(wData), .wData2(wData2),
        .int_pending(int_pending), .float_pending(float_pending),
        .err(err), .idle(idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of buffered writes plus the visible write port.
    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  r;
        logic [31:0] d;
        logic [31:0] d2;
    } ent_t;

    ent_t        q[$];
    logic        m_wsig, m_fw, m_dbl, m_err;
    logic [4:0]  m_wreg;
    logic [31:0] m_wd, m_wd2;
    logic [VW-1:0] obs_vec, exp_vec;

    function automatic logic [VW-1:0] exp_pack();
        logic [31:0] ip = '0;
        logic [31:0] fp = '0;
        logic rdy, idl;
        foreach (q[i]) begin
            if (q[i].kind == 2'd0) ip[q[i].r] = 1'b1;
            else begin
                fp[q[i].r] = 1'b1;
                if (q[i].kind == 2'd2) fp[q[i].r + 1] = 1'b1;
            end
        end
        rdy = (q.size() < DEPTH);
        idl = (q.size() == 0) && !m_wsig && !m_fw;
        return {rdy, m_wsig, m_fw, m_dbl, m_wreg, m_wd, m_wd2, ip, fp, m_err, idl};
    endfunction

    function automatic logic [VW-1:0] obs_pack();
        return {req_ready, regWSig, regwrite_float, double, wReg, wData, wData2,
                int_pending, float_pending, err, idle};
    endfunction

    task automatic model_reset();
        q.delete();
        m_wsig = 0; m_fw = 0; m_dbl = 0; m_err = 0;
        m_wreg = '0; m_wd = '0; m_wd2 = '0;
    endtask

    task automatic model_issue(input ent_t h);
        m_wsig = (h.kind == 2'd0);
        m_fw   = (h.kind != 2'd0);
        m_dbl  = (h.kind == 2'd2);
        m_wreg = h.r;
        m_wd   = h.d;
        m_wd2  = (h.kind == 2'd2) ? h.d2 : 32'd0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] k, input logic [4:0] r,
                              input logic [31:0] d, input logic [31:0] d2);
        logic acc, drp, st;
        ent_t e;
        acc = v && (q.size() < DEPTH);
        drp = (k == 2'd3) || (k == 2'd2 && r == 5'd31);
        st  = acc && !drp;
        e   = '{kind: k, r: r, d: d, d2: d2};
        m_err = acc && drp;
        if (q.size() > 0) begin
            model_issue(q.pop_front());
            if (st) q.push_back(e);
        end else if (st) begin
`ifdef WB_BYPASS_EN
            model_issue(e);
`else
            q.push_back(e);
            m_wsig = 0; m_fw = 0; m_dbl = 0;
`endif
        end else begin
            m_wsig = 0; m_fw = 0; m_dbl = 0;
        end
    endtask

    // One clock: drive request, advance DUT and model, sample 1 time unit later.
    task automatic cycle(input logic v, input logic [1:0] k, input logic [4:0] r,
                         input logic [31:0] d, input logic [31:0] d2);
        req_valid = v; req_kind = k; req_reg = r; req_data = d; req_data2 = d2;
        @(posedge clk);
        model_edge(v, k, r, d, d2);
        #1;
        obs_vec = obs_pack();
        exp_vec = exp_pack();
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 0; req_kind = 0; req_reg = 0; req_data = 0; req_data2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs_pack() !== exp_pack() || req_ready !== 1'b1 || idle !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", obs_pack(), exp_pack());
        end
        reset = 1'b0;
        cycle(1, 2'd0, 5'd9,  32'h1, 32'h0);
        cycle(1, 2'd2, 5'd10, 32'h2, 32'h3);
        cycle(1, 2'd1, 5'd12, 32'h4, 32'h0);
        #3 reset = 1'b1;
        #1;
        model_reset();
        total++;
        if (obs_pack() !== exp_pack()) begin
            bad++;
            $display("FAIL reset_midop got=%h exp=%h", obs_pack(), exp_pack());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(0, 2'd0, 5'd0, 32'h0, 32'h0);
        total++;
        if (obs_vec !== exp_vec || regWSig !== 1'b0 || regwrite_float !== 1'b0 ||
            int_pending !== '0 || float_pending !== '0) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_single_int();
        cycle(1, 2'd0, 5'd5, 32'h0000_00AA, 32'h0);
        total++;
`ifdef WB_BYPASS_EN
        if (obs_vec !== exp_vec || regWSig !== 1'b1 || int_pending[5] !== 1'b0) begin
`else
        if (obs_vec !== exp_vec || regWSig !== 1'b0 || int_pending[5] !== 1'b1) begin
`endif
            bad++;
            $display("FAIL single_accept got=%h exp=%h", obs_vec, exp_vec);
        end
        cycle(0, 2'd0, 5'd0, 32'h0, 32'h0);
        total++;
`ifdef WB_BYPASS_EN
        if (obs_vec !== exp_vec || regWSig !== 1'b0 || wData !== 32'hAA) begin
`else
        if (obs_vec !== exp_vec || regWSig !== 1'b1 || wReg !== 5'd5 ||
            wData !== 32'hAA || int_pending[5] !== 1'b0) begin
`endif
            bad++;
            $display("FAIL single_issue got=%h exp=%h", obs_vec, exp_vec);
        end
        cycle(0, 2'd0, 5'd0, 32'h0, 32'h0);
        total++;
        if (obs_vec !== exp_vec || regWSig !== 1'b0 || wData !== 32'hAA) begin
            bad++;
            $display("FAIL single_after got=%h exp=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_double();
        cycle(1, 2'd2, 5'd2, 32'h0100_0000, 32'h81C0_0000);
        total++;
`ifdef WB_BYPASS_EN
        if (obs_vec !== exp_vec || double !== 1'b1 || float_pending !== '0) begin
`else
        if (obs_vec !== exp_vec || float_pending !== 32'h0000_000C) begin
`endif
            bad++;
            $display("FAIL double_accept got=%h exp=%h", obs_vec, exp_vec);
        end
        cycle(1, 2'd2, 5'd31, 32'h5, 32'h6);
        total++;
`ifdef WB_BYPASS_EN
        if (obs_vec !== exp_vec || err !== 1'b1 || regwrite_float !== 1'b0) begin
`else
        if (obs_vec !== exp_vec || regwrite_float !== 1'b1 || double !== 1'b1 ||
            wReg !== 5'd2 || wData2 !== 32'h81C0_0000 || float_pending !== '0 ||
            err !== 1'b1) begin
`endif
            bad++;
            $display("FAIL double_issue got=%h exp=%h", obs_vec, exp_vec);
        end
        cycle(1, 2'd3, 5'd4, 32'h7, 32'h8);
        total++;
        if (obs_vec !== exp_vec || regwrite_float !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL double_drop got=%h exp=%h", obs_vec, exp_vec);
        end
        cycle(0, 2'd0, 5'd0, 32'h0, 32'h0);
        total++;
        if (obs_vec !== exp_vec || err !== 1'b0 || idle !== 1'b1) begin
            bad++;
            $display("FAIL drop_err_clear got=%h exp=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sent[$];
        logic [31:0] seen[$];
        for (int i = 0; i < 5; i++) begin
            sent.push_back($urandom);
            cycle(1, 2'd0, 5'(10 + i), sent[i], 32'h0);
            if (regWSig) seen.push_back(wData);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++;
                $display("FAIL b2b_push%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 2'd0, 5'd0, 32'h0, 32'h0);
            if (regWSig) seen.push_back(wData);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++;
                $display("FAIL b2b_drain%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
        end
        total++;
        if (seen != sent) begin
            bad++;
            $display("FAIL b2b_order got=%0d writes exp=%0d writes (first got=%h exp=%h)",
                     seen.size(), sent.size(), seen.size() > 0 ? seen[0] : 32'h0, sent[0]);
        end
    endtask

    task automatic test_same_reg();
        cycle(1, 2'd0, 5'd7, 32'h11, 32'h0);
        total++;
        if (obs_vec !== exp_vec) begin
            bad++;
            $display("FAIL same_first got=%h exp=%h", obs_vec, exp_vec);
        end
        cycle(1, 2'd0, 5'd7, 32'h22, 32'h0);
        total++;
`ifdef WB_BYPASS_EN
        if (obs_vec !== exp_vec || wData !== 32'h22) begin
`else
        if (obs_vec !== exp_vec || wData !== 32'h11 || int_pending[7] !== 1'b1) begin
`endif
            bad++;
            $display("FAIL same_second got=%h exp=%h", obs_vec, exp_vec);
        end
        cycle(0, 2'd0, 5'd0, 32'h0, 32'h0);
        total++;
        if (obs_vec !== exp_vec || wData !== 32'h22 || int_pending[7] !== 1'b0) begin
            bad++;
            $display("FAIL same_last got=%h exp=%h", obs_vec, exp_vec);
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        cycle(1, 2'd0, 5'd3, 32'h55, 32'h0);
        total++;
        if (obs_vec !== exp_vec || regWSig !== 1'b1 || wReg !== 5'd3 ||
            wData !== 32'h55 || int_pending !== '0) begin
            bad++;
            $display("FAIL bypass got=%h exp=%h", obs_vec, exp_vec);
        end
    endtask
`endif

    task automatic test_random();
        logic        v;
        logic [1:0]  k;
        logic [4:0]  r;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            k = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
            cycle(v, k, r, $urandom, $urandom);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++;
                $display("FAIL random%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_int();
        test_double();
        test_back_to_back();
        test_same_reg();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
